// File: rtl/assert_monitor.sv
// Clocked self-check collector: gathers NUM_CHECKS pass/fail strobes per cycle into
// sticky error flags, saturating counters and a first-failure capture.
module assert_monitor #(
  parameter int NUM_CHECKS   = 2,
  parameter int CNT_WIDTH    = 8,
  parameter bit STOP_ON_FAIL = 1'b0,
  localparam int ID_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [NUM_CHECKS-1:0] chk_valid,
  input  logic [NUM_CHECKS-1:0] chk_pass,
  output logic                  error,
  output logic [NUM_CHECKS-1:0] fail_mask,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  first_fail_valid,
  output logic [ID_W-1:0]       first_fail_id,
  output logic                  frozen
);

  // Sum width leaves room for a full-width increment so saturation is decided before any wrap.
  localparam int PC_W  = $clog2(NUM_CHECKS + 1);
  localparam int SUM_W = CNT_WIDTH + PC_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t                state;
  logic                  accept;
  logic [NUM_CHECKS-1:0] fail_vec;
  logic [NUM_CHECKS-1:0] pass_vec;
  logic [PC_W-1:0]       fail_pop;
  logic [PC_W-1:0]       pass_pop;
  logic [ID_W-1:0]       low_id;
  logic [SUM_W-1:0]      fail_sum;
  logic [SUM_W-1:0]      pass_sum;
  logic [CNT_WIDTH-1:0]  fail_next;
  logic [CNT_WIDTH-1:0]  pass_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    accept   = (state == RUN) && enable && !clear;
    fail_vec = '0;
    pass_vec = '0;
    fail_pop = '0;
    pass_pop = '0;
    low_id   = '0;
    if (accept) begin
      fail_vec = chk_valid & ~chk_pass;
      pass_vec = chk_valid & chk_pass;
    end
    // Scanning downward leaves the lowest failing index as the final assignment.
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (fail_vec[i]) low_id = ID_W'(i);
      fail_pop = fail_pop + PC_W'(fail_vec[i]);
      pass_pop = pass_pop + PC_W'(pass_vec[i]);
    end
    fail_sum  = SUM_W'(fail_count) + SUM_W'(fail_pop);
    pass_sum  = SUM_W'(pass_count) + SUM_W'(pass_pop);
    fail_next = (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_WIDTH-1:0];
    pass_next = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state            <= IDLE;
      error            <= 1'b0;
      fail_mask        <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_id    <= '0;
      frozen           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (STOP_ON_FAIL && accept && (|fail_vec)) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (clear) begin
            state  <= IDLE;
            frozen <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          frozen <= 1'b0;
        end
      endcase

      if (clear) begin
        error            <= 1'b0;
        fail_mask        <= '0;
        pass_count       <= '0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_id    <= '0;
      end else if (accept) begin
        error      <= error | (|fail_vec);
        fail_mask  <= fail_mask | fail_vec;
        fail_count <= fail_next;
        pass_count <= pass_next;
        if (!first_fail_valid && (|fail_vec)) begin
          first_fail_valid <= 1'b1;
          first_fail_id    <= low_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_assert_monitor.sv
// Scoreboard bench for assert_monitor: one free-running and one stop-on-fail instance
// share stimulus; a spec-level model predicts each cycle's outputs for both.
module tb_assert_monitor;

  localparam int NC = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [NC-1:0] chk_valid = '0;
  logic [NC-1:0] chk_pass = '0;

  logic          error_a, ffv_a, frozen_a, error_b, ffv_b, frozen_b;
  logic [NC-1:0] mask_a, mask_b;
  logic [CW-1:0] pc_a, fc_a, pc_b, fc_b;
  logic [1:0]    ffid_a, ffid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assert_monitor #(.NUM_CHECKS(NC), .CNT_WIDTH(CW), .STOP_ON_FAIL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .chk_valid(chk_valid), .chk_pass(chk_pass),
    .error(error_a), .fail_mask(mask_a), .pass_count(pc_a), .fail_count(fc_a),
    .first_fail_valid(ffv_a), .first_fail_id(ffid_a), .frozen(frozen_a)
  );

  assert_monitor #(.NUM_CHECKS(NC), .CNT_WIDTH(CW), .STOP_ON_FAIL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .chk_valid(chk_valid), .chk_pass(chk_pass),
    .error(error_b), .fail_mask(mask_b), .pass_count(pc_b), .fail_count(fc_b),
    .first_fail_valid(ffv_b), .first_fail_id(ffid_b), .frozen(frozen_b)
  );

  // armed = checks currently counted on the following cycles; frz = stopped after a failure.
  typedef struct {
    bit armed;
    bit frz;
    bit err;
    int mask;
    int pc;
    int fc;
    bit ffv;
    int ffid;
  } model_t;

  typedef struct {
    model_t a;
    model_t b;
  } exp_t;

  exp_t   exp_q[$];
  model_t ma, mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t zero_acc(input model_t m);
    model_t r = m;
    r.err = 0; r.mask = 0; r.pc = 0; r.fc = 0; r.ffv = 0; r.ffid = 0;
    return r;
  endfunction

  task automatic model_step(input model_t cur, input bit stop, input bit r, input bit en,
                            input bit clr, input int v, input int p, output model_t nxt);
    int fails, passes;
    nxt = cur;
    if (!r) begin
      nxt = '{default: 0};
    end else if (cur.frz) begin
      if (clr) begin
        nxt = zero_acc(cur);
        nxt.frz = 0;
        nxt.armed = 0;
      end
    end else if (!cur.armed) begin
      if (clr) nxt = zero_acc(cur);
      nxt.armed = en;
    end else if (clr) begin
      nxt = zero_acc(cur);
      nxt.armed = en;
    end else if (!en) begin
      nxt.armed = 0;
    end else begin
      fails  = v & ~p & 'hF;
      passes = v & p & 'hF;
      nxt.mask = cur.mask | fails;
      nxt.err  = cur.err || (fails != 0);
      nxt.fc   = (cur.fc + $countones(fails) > CMAX) ? CMAX : cur.fc + $countones(fails);
      nxt.pc   = (cur.pc + $countones(passes) > CMAX) ? CMAX : cur.pc + $countones(passes);
      if (!cur.ffv && fails != 0) begin
        nxt.ffv = 1;
        for (int i = NC - 1; i >= 0; i--) if ((fails >> i) & 1) nxt.ffid = i;
      end
      if (stop && fails != 0) begin
        nxt.frz = 1;
        nxt.armed = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit clr, input int v, input int p);
    model_t na, nb;
    exp_t e;
    @(negedge clk);
    rst_n = r; enable = en; clear = clr;
    chk_valid = NC'(v); chk_pass = NC'(p);
    model_step(ma, 1'b0, r, en, clr, v, p, na);
    model_step(mb, 1'b1, r, en, clr, v, p, nb);
    ma = na; mb = nb;
    e.a = na; e.b = nb;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string t, input model_t e, input logic err, input logic [NC-1:0] mask,
                         input logic [CW-1:0] pc, input logic [CW-1:0] fc, input logic ffv,
                         input logic [1:0] ffid, input logic frz);
    check({t, ".error"}, 32'(err), 32'(e.err));
    check({t, ".fail_mask"}, 32'(mask), e.mask);
    check({t, ".pass_count"}, 32'(pc), e.pc);
    check({t, ".fail_count"}, 32'(fc), e.fc);
    check({t, ".first_fail_valid"}, 32'(ffv), 32'(e.ffv));
    check({t, ".first_fail_id"}, 32'(ffid), e.ffid);
    check({t, ".frozen"}, 32'(frz), 32'(e.frz));
  endtask

  // Monitor: every edge after a stimulus, pop the prediction and compare both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("free", e.a, error_a, mask_a, pc_a, fc_a, ffv_a, ffid_a, frozen_a);
        compare("stop", e.b, error_b, mask_b, pc_b, fc_b, ffv_b, ffid_b, frozen_b);
      end
    end
  end

  initial begin
    int v, p;
    bit r, en, clr;
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset, then three all-pass enabled cycles; the first is swallowed by IDLE->RUN.
    repeat (2) drive(0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 'hF, 'hF);
    // Multiple failures, then a later failure that must not move first_fail_id.
    drive(1, 1, 0, 'hF, 'h5);
    drive(1, 1, 0, 'hF, 'hE);
    // Saturation from zero (clear keeps RUN while enable stays high).
    drive(1, 1, 1, 0, 0);
    repeat (5) drive(1, 1, 0, 'hF, 'h0);
    // Clear beats a simultaneous failure.
    drive(1, 1, 1, 'h1, 'h0);
    drive(1, 1, 0, 'h0, 'h0);
    // Stop-on-fail: arm, fail on channel 2, more failures on 0, clear, re-arm.
    drive(1, 1, 0, 'h0, 'h0);
    drive(1, 1, 0, 'h4, 'h0);
    repeat (2) drive(1, 1, 0, 'h1, 'h0);
    drive(1, 1, 1, 'h0, 'h0);
    drive(1, 1, 0, 'hF, 'h0);
    drive(1, 1, 0, 'h3, 'h1);
    // enable drop discards checks; reset while frozen with error set.
    drive(1, 0, 0, 'hF, 'h0);
    drive(0, 1, 0, 'hF, 'h0);
    drive(1, 0, 0, 'h0, 'h0);

    // Randomised traffic with occasional clear/reset/disable.
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) >= 2);
      en  = ($urandom_range(0, 99) < 90);
      clr = ($urandom_range(0, 99) < 5);
      v   = $urandom_range(0, 15);
      p   = ($urandom_range(0, 1) == 1) ? 'hF : $urandom_range(0, 15);
      drive(r, en, clr, v, p);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
